// File: rtl/mmio_pwm_if.sv
// ---------------------------------------------------------------------------
// mmio_pwm_if
// Processor-side memory-mapped bus for the PWM block.
//
//   write_mem      write strobe
//   funct3         access size (3'b010 = 32-bit word)
//   write_address  byte address of the write
//   write_data     write payload
//   read_address   byte address of the read
//   read_data      registered read response (one cycle after read_address)
//
// master: the processor side.  slave: the PWM peripheral.
// ---------------------------------------------------------------------------
interface mmio_pwm_if;
    logic        write_mem;
    logic [2:0]  funct3;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic [31:0] read_address;
    logic [31:0] read_data;

    modport master (
        output write_mem,
        output funct3,
        output write_address,
        output write_data,
        output read_address,
        input  read_data
    );

    modport slave (
        input  write_mem,
        input  funct3,
        input  write_address,
        input  write_data,
        input  read_address,
        output read_data
    );
endinterface

// File: rtl/mmio_pwm.sv
// ---------------------------------------------------------------------------
// mmio_pwm
// Four-channel PWM generator behind a 32-byte memory-mapped register window.
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous, active-low
//   bus          mmio_pwm_if.slave register access (word writes only)
//   pwm[3:0]     registered channel outputs
//   period_tick  one-cycle pulse for each counter wrap
//
// Register map (word index = address[4:2])
//   0 CTRL    bit0 EN, bits[15:8] PRESC
//   1 PERIOD  [CNT_W-1:0]
//   2..5 DUTY0..DUTY3  [CNT_W-1:0]
//   6 STATUS  bit0 WRAP (write 1 to clear, a simultaneous wrap wins)
//   7 reserved, reads 0
//
// PERIOD and DUTYn are shadow registers; the counter compares against active
// copies that are reloaded at each wrap, and continuously while disabled.
// ---------------------------------------------------------------------------
module mmio_pwm #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter int          CNT_W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    mmio_pwm_if.slave    bus,
    output logic [3:0]   pwm,
    output logic         period_tick
);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]       PRE_ONE  = 8'd1;

    localparam logic [2:0] IDX_CTRL   = 3'd0;
    localparam logic [2:0] IDX_PERIOD = 3'd1;
    localparam logic [2:0] IDX_DUTY0  = 3'd2;
    localparam logic [2:0] IDX_DUTY1  = 3'd3;
    localparam logic [2:0] IDX_DUTY2  = 3'd4;
    localparam logic [2:0] IDX_DUTY3  = 3'd5;
    localparam logic [2:0] IDX_STATUS = 3'd6;

    function automatic logic addr_hit(input logic [31:0] addr);
        return addr[31:5] == BASE_ADDR[31:5];
    endfunction

    // Programmed (shadow) registers
    logic             en;
    logic [7:0]       presc;
    logic [CNT_W-1:0] period_sh;
    logic [CNT_W-1:0] duty_sh [4];
    logic             wrap_flag;

    // Running state and active copies
    logic [7:0]       presc_cnt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_act;
    logic [CNT_W-1:0] duty_act [4];

    logic             wr_en;
    logic [2:0]       wr_idx;
    logic             tick;
    logic             wrap;
    logic [31:0]      rd_val;

    logic             unused_bits;
    assign unused_bits = ^{bus.write_data[31:16], bus.write_address[1:0],
                           bus.read_address[1:0]};

    assign wr_en  = bus.write_mem && addr_hit(bus.write_address) &&
                    (bus.funct3 == 3'b010);
    assign wr_idx = bus.write_address[4:2];

    // ">=" rather than "==" so that lowering PRESC below the running
    // prescaler count ticks immediately instead of rolling through 255.
    assign tick = en && (presc_cnt >= presc);
    assign wrap = tick && (cnt == period_act);

    // Register file writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en        <= 1'b0;
            presc     <= '0;
            period_sh <= '0;
            for (int i = 0; i < 4; i++) duty_sh[i] <= '0;
        end else if (wr_en) begin
            case (wr_idx)
                IDX_CTRL: begin
                    en    <= bus.write_data[0];
                    presc <= bus.write_data[15:8];
                end
                IDX_PERIOD: period_sh  <= bus.write_data[CNT_W-1:0];
                IDX_DUTY0:  duty_sh[0] <= bus.write_data[CNT_W-1:0];
                IDX_DUTY1:  duty_sh[1] <= bus.write_data[CNT_W-1:0];
                IDX_DUTY2:  duty_sh[2] <= bus.write_data[CNT_W-1:0];
                IDX_DUTY3:  duty_sh[3] <= bus.write_data[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    // Wrap status: a wrap in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap_flag <= 1'b0;
        end else if (wrap) begin
            wrap_flag <= 1'b1;
        end else if (wr_en && (wr_idx == IDX_STATUS) && bus.write_data[0]) begin
            wrap_flag <= 1'b0;
        end
    end

    // Prescaler, counter, active copies and outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_cnt   <= '0;
            cnt         <= '0;
            period_act  <= '0;
            for (int i = 0; i < 4; i++) duty_act[i] <= '0;
            period_tick <= 1'b0;
            pwm         <= '0;
        end else if (!en) begin
            // Idle: hold counters at zero and track the programmed values so
            // enabling starts a full period with the latest settings.
            presc_cnt   <= '0;
            cnt         <= '0;
            period_act  <= period_sh;
            for (int i = 0; i < 4; i++) duty_act[i] <= duty_sh[i];
            period_tick <= 1'b0;
            pwm         <= '0;
        end else begin
            presc_cnt <= tick ? 8'd0 : (presc_cnt + PRE_ONE);
            if (tick) begin
                cnt <= wrap ? '0 : (cnt + CNT_ONE);
            end
            if (wrap) begin
                period_act <= period_sh;
                for (int i = 0; i < 4; i++) duty_act[i] <= duty_sh[i];
            end
            period_tick <= wrap;
            // Counter spans 0..period_act, so duty > period_act is always high
            for (int i = 0; i < 4; i++) pwm[i] <= (cnt < duty_act[i]);
        end
    end

    // Read mux
    always_comb begin
        rd_val = '0;
        case (bus.read_address[4:2])
            IDX_CTRL:   rd_val = {16'h0000, presc, 7'h00, en};
            IDX_PERIOD: rd_val[CNT_W-1:0] = period_sh;
            IDX_DUTY0:  rd_val[CNT_W-1:0] = duty_sh[0];
            IDX_DUTY1:  rd_val[CNT_W-1:0] = duty_sh[1];
            IDX_DUTY2:  rd_val[CNT_W-1:0] = duty_sh[2];
            IDX_DUTY3:  rd_val[CNT_W-1:0] = duty_sh[3];
            IDX_STATUS: rd_val[0] = wrap_flag;
            default:    rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.read_data <= '0;
        end else begin
            bus.read_data <= addr_hit(bus.read_address) ? rd_val : 32'h0;
        end
    end

endmodule

// File: tb/tb_mmio_pwm.sv
module tb_mmio_pwm;

    localparam logic [31:0] BASE   = 32'hFFFF_FF00;
    localparam logic [31:0] A_CTRL = BASE + 32'd0;
    localparam logic [31:0] A_PER  = BASE + 32'd4;
    localparam logic [31:0] A_D0   = BASE + 32'd8;
    localparam logic [31:0] A_D1   = BASE + 32'd12;
    localparam logic [31:0] A_D2   = BASE + 32'd16;
    localparam logic [31:0] A_D3   = BASE + 32'd20;
    localparam logic [31:0] A_ST   = BASE + 32'd24;
    localparam logic [31:0] A_RES  = BASE + 32'd28;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] pwm;
    logic       period_tick;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rd_q[$];   // expected read responses
    logic [1:0]  pat_q[$];  // expected {pwm[0], period_tick} per cycle

    always #5 clk = ~clk;

    mmio_pwm_if bus();

    mmio_pwm #(.BASE_ADDR(BASE), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .pwm         (pwm),
        .period_tick (period_tick)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                      input logic [2:0] f3, input logic we);
        bus.write_mem     = we;
        bus.funct3        = f3;
        bus.write_address = addr;
        bus.write_data    = data;
        step();
        bus.write_mem     = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        bus.read_address = addr;
        step();
        data = bus.read_data;
    endtask

    task automatic align(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (period_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // pattern bits left to right are pwm[0] for cnt = 0,1,2,3
    task automatic push_pat(input logic [3:0] p, input int reps);
        for (int r = 0; r < reps; r++)
            for (int k = 3; k >= 0; k--)
                pat_q.push_back({p[k], (k == 0)});
    endtask

    task automatic test_reset();
        logic [31:0] got, e;
        reset = 1'b0;
        #12;
        checks++;
        if (pwm !== 4'h0 || period_tick !== 1'b0 || bus.read_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs pwm=%h tick=%b rdata=%h required 0/0/0",
                     pwm, period_tick, bus.read_data);
        end
        @(posedge clk); #2;
        reset = 1'b1;
        rd_q.push_back(32'h0);
        rd(A_CTRL, got);
        e = rd_q.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL reset_ctrl got=%h required=%h", got, e);
        end
        rd_q.push_back(32'h0);
        rd(A_ST, got);
        e = rd_q.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL reset_status got=%h required=%h", got, e);
        end
    endtask

    task automatic test_basic();
        bit ok;
        logic [1:0] e;
        logic [31:0] got, er;
        wr(A_PER, 32'd3, 3'b010, 1'b1);
        wr(A_D0, 32'd2, 3'b010, 1'b1);
        wr(A_CTRL, 32'h1, 3'b010, 1'b1);
        align(20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL basic_align no period_tick within 20 cycles");
        end
        push_pat(4'b1100, 3);
        for (int i = 0; i < 12; i++) begin
            step();
            e = pat_q.pop_front();
            checks++;
            if ({pwm[0], period_tick} !== e) begin
                failures++;
                $display("FAIL basic_pattern cyc=%0d got=%b required=%b", i,
                         {pwm[0], period_tick}, e);
            end
        end
        rd_q.push_back(32'h1);
        rd(A_ST, got);
        er = rd_q.pop_front();
        checks++;
        if (got !== er) begin
            failures++;
            $display("FAIL basic_status got=%h required=%h", got, er);
        end
    endtask

    task automatic test_double_buffer();
        bit ok;
        logic [1:0] e;
        logic [31:0] got, er;
        align(20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL dbuf_align no period_tick within 20 cycles");
        end
        push_pat(4'b1100, 1);
        push_pat(4'b1000, 2);
        for (int i = 0; i < 12; i++) begin
            if (i == 1) begin
                bus.write_mem     = 1'b1;
                bus.funct3        = 3'b010;
                bus.write_address = A_D0;
                bus.write_data    = 32'd1;
            end
            step();
            bus.write_mem = 1'b0;
            e = pat_q.pop_front();
            checks++;
            if ({pwm[0], period_tick} !== e) begin
                failures++;
                $display("FAIL dbuf_pattern cyc=%0d got=%b required=%b", i,
                         {pwm[0], period_tick}, e);
            end
        end
        rd_q.push_back(32'h1);
        rd(A_D0, got);
        er = rd_q.pop_front();
        checks++;
        if (got !== er) begin
            failures++;
            $display("FAIL dbuf_readback got=%h required=%h", got, er);
        end
    endtask

    task automatic test_limits();
        bit ok;
        int n, ones;
        wr(A_D1, 32'd0, 3'b010, 1'b1);
        wr(A_D2, 32'd4, 3'b010, 1'b1);
        align(20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL limits_align no period_tick within 20 cycles");
        end
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (pwm[2:1] !== 2'b10) begin
                failures++;
                $display("FAIL limits_duty cyc=%0d pwm[2:1]=%b required=10", i, pwm[2:1]);
            end
        end
        wr(A_CTRL, 32'h0000_0201, 3'b010, 1'b1);
        align(40, ok);
        n = 0;
        ones = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            n++;
            ones += int'(pwm[0]);
            if (period_tick === 1'b1) break;
        end
        checks++;
        if (!ok || n != 12) begin
            failures++;
            $display("FAIL presc_period got=%0d cycles required=12", n);
        end
        checks++;
        if (ones != 3) begin
            failures++;
            $display("FAIL presc_high got=%0d cycles required=3", ones);
        end
    endtask

    task automatic test_bus_filter();
        logic [31:0] got, e;
        logic [31:0] addrs [6];
        logic [31:0] exps  [6];
        wr(A_D3, 32'h0000_00A0, 3'b010, 1'b1);
        wr(A_D3, 32'h0000_0055, 3'b000, 1'b1);          // byte write
        wr(A_D3, 32'h0000_0055, 3'b010, 1'b0);          // no strobe
        wr(BASE + 32'd52, 32'h0000_0055, 3'b010, 1'b1); // miss, aliases DUTY3
        wr(A_PER, 32'hFFFF_FF03, 3'b010, 1'b1);         // upper bits ignored
        wr(A_RES, 32'hFFFF_FFFF, 3'b010, 1'b1);
        addrs = '{A_D3, BASE + 32'd32, A_RES, A_PER, A_CTRL, A_D2};
        exps  = '{32'hA0, 32'h0, 32'h0, 32'h3, 32'h201, 32'h4};
        for (int i = 0; i < 6; i++) begin
            rd_q.push_back(exps[i]);
            rd(addrs[i], got);
            e = rd_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL bus_read addr=%h got=%h required=%h", addrs[i], got, e);
            end
        end
    endtask

    task automatic test_status();
        bit ok;
        logic [31:0] got, e;
        align(40, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL status_align no period_tick within 40 cycles");
        end
        for (int i = 0; i < 11; i++) step();
        bus.write_mem     = 1'b1;
        bus.funct3        = 3'b010;
        bus.write_address = A_ST;
        bus.write_data    = 32'h1;
        step();
        bus.write_mem = 1'b0;
        checks++;
        if (period_tick !== 1'b1) begin
            failures++;
            $display("FAIL status_wrapcycle tick=%b required=1", period_tick);
        end
        rd_q.push_back(32'h1);
        rd(A_ST, got);
        e = rd_q.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL status_setwins got=%h required=%h", got, e);
        end
        align(40, ok);
        step();
        step();
        wr(A_ST, 32'h1, 3'b010, 1'b1);
        rd_q.push_back(32'h0);
        rd(A_ST, got);
        e = rd_q.pop_front();
        checks++;
        if (!ok || got !== e) begin
            failures++;
            $display("FAIL status_clear got=%h required=%h", got, e);
        end
    endtask

    task automatic test_period_zero();
        bit ok1, ok2;
        wr(A_CTRL, 32'h1, 3'b010, 1'b1);
        wr(A_PER, 32'h0, 3'b010, 1'b1);
        align(20, ok1);
        align(20, ok2);
        checks++;
        if (!ok1 || !ok2) begin
            failures++;
            $display("FAIL pzero_align no period_tick within 20 cycles");
        end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if ({pwm, period_tick} !== 5'b11011) begin
                failures++;
                $display("FAIL pzero cyc=%0d got=%b required=11011", i, {pwm, period_tick});
            end
        end
    endtask

    task automatic test_disable_enable();
        logic [1:0] e;
        wr(A_CTRL, 32'h0, 3'b010, 1'b1);
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (pwm !== 4'h0 || period_tick !== 1'b0) begin
                failures++;
                $display("FAIL disabled cyc=%0d pwm=%h tick=%b required 0/0", i, pwm, period_tick);
            end
        end
        wr(A_PER, 32'd3, 3'b010, 1'b1);
        wr(A_D0, 32'd2, 3'b010, 1'b1);
        wr(A_CTRL, 32'h1, 3'b010, 1'b1);
        push_pat(4'b1100, 2);
        for (int i = 0; i < 8; i++) begin
            step();
            e = pat_q.pop_front();
            checks++;
            if ({pwm[0], period_tick} !== e) begin
                failures++;
                $display("FAIL enable_start cyc=%0d got=%b required=%b", i,
                         {pwm[0], period_tick}, e);
            end
        end
    endtask

    task automatic test_reset_running();
        bit ok;
        logic [31:0] got, e;
        align(20, ok);
        step();
        bus.read_address = A_PER;
        step();
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (!ok || pwm !== 4'h0 || period_tick !== 1'b0 || bus.read_data !== 32'h0) begin
            failures++;
            $display("FAIL async_reset pwm=%h tick=%b rdata=%h required 0/0/0",
                     pwm, period_tick, bus.read_data);
        end
        #7;
        reset = 1'b1;
        rd_q.push_back(32'h0);
        rd(A_CTRL, got);
        e = rd_q.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL post_reset_ctrl got=%h required=%h", got, e);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (pwm !== 4'h0) begin
                failures++;
                $display("FAIL post_reset_pwm cyc=%0d got=%h required=0", i, pwm);
            end
        end
    endtask

    initial begin
        bus.write_mem     = 1'b0;
        bus.funct3        = 3'b000;
        bus.write_address = 32'h0;
        bus.write_data    = 32'h0;
        bus.read_address  = 32'h0;
        test_reset();
        test_basic();
        test_double_buffer();
        test_limits();
        test_bus_filter();
        test_status();
        test_period_zero();
        test_disable_enable();
        test_reset_running();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
